// File: rtl/bitstream_pkg.sv
// Shared types and constants for the stochastic bitstream evaluation engine.
package bitstream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_COUNT,
        ST_DONE
    } state_t;

    // Taps of x^16+x^14+x^13+x^11+1 for a shift-left Fibonacci register.
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam int          SEED_STRIDE = 235;

    function automatic logic [15:0] lfsr_seed(input int base, input int idx);
        int sum;
        sum = base + idx * SEED_STRIDE;
        lfsr_seed = (sum[15:0] == 16'h0000) ? 16'h0001 : sum[15:0];
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload of its seed.
module lfsr16
    import bitstream_pkg::*;
#(
    parameter logic [15:0] SEED = 16'h0001
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        load,
    input  logic        enable,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (enable) begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/bitstream_runner.sv
// Drives stochastic bitstreams into a layer network, counts the returned ones
// over a fixed window after a flush period, and reports per-channel counts and argmax.
module bitstream_runner
    import bitstream_pkg::*;
#(
    parameter int INPUT_SIZE  = 4,
    parameter int OUTPUT_SIZE = 3,
    parameter int VALUE_WIDTH = 8,
    parameter int WARMUP      = 16,
    parameter int WINDOW      = 256,
    parameter int SEED        = 25,
    localparam int CW  = $clog2(WINDOW + 1),
    localparam int CLW = (OUTPUT_SIZE > 2) ? $clog2(OUTPUT_SIZE) : 1
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [INPUT_SIZE*VALUE_WIDTH-1:0] input_value,
    output logic [INPUT_SIZE-1:0]             bs_input,
    input  logic [OUTPUT_SIZE-1:0]            bs_output,
    output logic                              ready,
    output logic                              done,
    output logic [OUTPUT_SIZE*CW-1:0]         result_count,
    output logic [CLW-1:0]                    result_class,
    output logic                              result_valid
);

    localparam int PMAX = (WARMUP > WINDOW) ? WARMUP : WINDOW;
    localparam int PW   = $clog2(PMAX + 1);

    state_t                 state;
    logic [PW-1:0]          phase;
    logic [CW-1:0]          counts [OUTPUT_SIZE];
    logic [VALUE_WIDTH-1:0] values [INPUT_SIZE];
    logic [VALUE_WIDTH-1:0] lfsr_low [INPUT_SIZE];
    logic [CLW-1:0]         best;
    logic                   running;
    logic                   load;

    assign running = (state == ST_WARMUP) || (state == ST_COUNT);
    assign load    = (state == ST_IDLE) && start;
    assign ready   = (state == ST_IDLE);
    assign done    = (state == ST_DONE);

    for (genvar g = 0; g < INPUT_SIZE; g++) begin : g_lfsr
        logic [15:0] st;
        lfsr16 #(
            .SEED(lfsr_seed(SEED, g))
        ) u_lfsr (
            .clk   (clk),
            .n_rst (n_rst),
            .load  (load),
            .enable(running),
            .state (st)
        );
        assign lfsr_low[g] = st[VALUE_WIDTH-1:0];
        if (VALUE_WIDTH < 16) begin : g_hi
            // Only the low bits feed the comparator; the rest just shift through.
            logic lfsr_unused;
            assign lfsr_unused = ^st[15:VALUE_WIDTH];
        end
    end

    always_comb begin
        bs_input = '0;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            bs_input[i] = running && (lfsr_low[i] < values[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < INPUT_SIZE; i++) begin
                values[i] <= input_value[i*VALUE_WIDTH +: VALUE_WIDTH];
            end
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        logic [CW-1:0] best_count;
        best       = '0;
        best_count = counts[0];
        for (int j = 1; j < OUTPUT_SIZE; j++) begin
            if (counts[j] > best_count) begin
                best_count = counts[j];
                best       = CLW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= ST_IDLE;
            phase        <= '0;
            result_count <= '0;
            result_class <= '0;
            result_valid <= 1'b0;
            for (int j = 0; j < OUTPUT_SIZE; j++) begin
                counts[j] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        phase <= '0;
                        for (int j = 0; j < OUTPUT_SIZE; j++) begin
                            counts[j] <= '0;
                        end
                        state <= (WARMUP == 0) ? ST_COUNT : ST_WARMUP;
                    end
                end
                ST_WARMUP: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (phase == PW'(WARMUP - 1)) begin
                        phase <= '0;
                        state <= ST_COUNT;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                ST_COUNT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        for (int j = 0; j < OUTPUT_SIZE; j++) begin
                            if (bs_output[j]) begin
                                counts[j] <= counts[j] + CW'(1);
                            end
                        end
                        if (phase == PW'(WINDOW - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            phase <= phase + PW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (!abort) begin
                        for (int j = 0; j < OUTPUT_SIZE; j++) begin
                            result_count[j*CW +: CW] <= counts[j];
                        end
                        result_class <= best;
                        result_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitstream_runner.sv
// Randomized bench for bitstream_runner against a cycle-indexed behavioural model.
module tb_bitstream_runner;

    localparam int IN_N  = 4;
    localparam int OUT_N = 3;
    localparam int VW    = 8;
    localparam int WU    = 16;
    localparam int WIN   = 256;
    localparam int SD    = 25;
    localparam int CW    = 9;
    localparam int RUN   = WU + WIN;

    logic                  clk = 1'b0;
    logic                  n_rst = 1'b0;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic [IN_N*VW-1:0]    input_value = '0;
    logic [IN_N-1:0]       bs_input;
    logic [OUT_N-1:0]      bs_output = '0;
    logic                  ready;
    logic                  done;
    logic [OUT_N*CW-1:0]   result_count;
    logic [1:0]            result_class;
    logic                  result_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bitstream_runner #(
        .INPUT_SIZE (IN_N),
        .OUTPUT_SIZE(OUT_N),
        .VALUE_WIDTH(VW),
        .WARMUP     (WU),
        .WINDOW     (WIN),
        .SEED       (SD)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .abort       (abort),
        .input_value (input_value),
        .bs_input    (bs_input),
        .bs_output   (bs_output),
        .ready       (ready),
        .done        (done),
        .result_count(result_count),
        .result_class(result_class),
        .result_valid(result_valid)
    );

    // Behavioural model: m_e counts edges since the start edge of the active run.
    bit          m_active = 1'b0;
    int          m_e = 0;
    logic [15:0] m_lfsr [IN_N];
    logic [VW-1:0] m_val [IN_N];
    int          m_cnt [OUT_N];
    int          m_res [OUT_N] = '{default: 0};
    int          m_class = 0;
    bit          m_valid = 1'b0;

    function automatic logic [15:0] seed_of(input int i);
        int s;
        s = (SD + i * 235) % 65536;
        return (s == 0) ? 16'h0001 : 16'(s);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_active = 1'b0;
            m_e      = 0;
            m_valid  = 1'b0;
            m_class  = 0;
            for (int j = 0; j < OUT_N; j++) m_res[j] = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_e      = 0;
                for (int i = 0; i < IN_N; i++) begin
                    m_val[i]  = input_value[i*VW +: VW];
                    m_lfsr[i] = seed_of(i);
                end
                for (int j = 0; j < OUT_N; j++) m_cnt[j] = 0;
            end
        end else if (abort) begin
            m_active = 1'b0;
        end else begin
            if (m_e >= WU && m_e < RUN)
                for (int j = 0; j < OUT_N; j++) m_cnt[j] += int'(bs_output[j]);
            if (m_e < RUN)
                for (int i = 0; i < IN_N; i++) m_lfsr[i] = lfsr_next(m_lfsr[i]);
            if (m_e == RUN) begin
                m_class = 0;
                for (int j = 0; j < OUT_N; j++) begin
                    m_res[j] = m_cnt[j];
                    if (m_cnt[j] > m_cnt[m_class]) m_class = j;
                end
                m_valid  = 1'b1;
                m_active = 1'b0;
            end
            m_e++;
        end
    end

    int            done_seen = 0;
    int            ones [IN_N] = '{default: 0};
    int            cap = 0;
    logic [IN_N-1:0] seq_a [RUN];
    logic [IN_N-1:0] seq_b [RUN];

    always @(negedge clk) begin : compare
        logic [IN_N-1:0]     e_bs;
        logic [OUT_N*CW-1:0] e_rc;
        logic                e_ready;
        logic                e_done;
        e_bs = '0;
        for (int i = 0; i < IN_N; i++)
            e_bs[i] = m_active && (m_e < RUN) && (m_lfsr[i][VW-1:0] < m_val[i]);
        for (int j = 0; j < OUT_N; j++) e_rc[j*CW +: CW] = CW'(m_res[j]);
        e_ready = !m_active;
        e_done  = m_active && (m_e == RUN);
        tests++;
        if (ready !== e_ready || done !== e_done || bs_input !== e_bs ||
            result_count !== e_rc || result_class !== 2'(m_class) || result_valid !== m_valid) begin
            fails++;
            $display("FAIL cycle_compare t=%0t ready=%b/%b done=%b/%b bs_input=%b/%b count=%h/%h class=%0d/%0d valid=%b/%b",
                     $time, ready, e_ready, done, e_done, bs_input, e_bs, result_count, e_rc,
                     result_class, m_class, result_valid, m_valid);
        end
        if (done === 1'b1) done_seen++;
        if (m_active && m_e >= WU && m_e < RUN)
            for (int i = 0; i < IN_N; i++) ones[i] += int'(bs_input[i]);
        if (m_active && m_e < RUN) begin
            if (cap == 1) seq_a[m_e] = bs_input;
            else if (cap == 2) seq_b[m_e] = bs_input;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // mode 0: random bs_output and stray start pulses; mode 1: a during warmup, b during count.
    task automatic run(input int mode, input logic [OUT_N-1:0] a, input logic [OUT_N-1:0] b,
                       output int lat);
        lat = -1;
        for (int k = 1; k <= 600; k++) begin
            if (mode == 0) begin
                bs_output = 3'($urandom);
                start     = ($urandom_range(0, 15) == 0);
            end else begin
                bs_output = (k <= WU) ? a : b;
            end
            step(1);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        start     = 1'b0;
        bs_output = '0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : main
        int lat;
        int d0;
        int o0 [IN_N];
        int mism;
        logic [OUT_N*CW-1:0] held_rc;
        logic [1:0]          held_cls;

        step(3);
        n_rst = 1'b1;
        step(1);
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_bs_input", bs_input, 0);
        check("reset_count", result_count, 0);
        check("reset_class", result_class, 0);
        check("reset_valid", result_valid, 0);

        // Seeds low bytes are 25, 4, 239, 218 for channels 0..3.
        input_value = {8'd0, 8'd240, 8'd4, 8'd26};
        do_start();
        check("first_bits", bs_input, 4'b0101);
        run(1, 3'b101, 3'b101, lat);
        // done is visible in the cycle ending at edge T+1+WARMUP+WINDOW.
        check("latency_default", lat, 272);
        step(1);
        check("count_101", result_count, {9'd256, 9'd0, 9'd256});
        check("class_101", result_class, 0);
        check("valid_101", result_valid, 1);

        input_value = $urandom;
        do_start();
        run(1, 3'b010, 3'b100, lat);
        check("latency_warmup", lat, 272);
        step(1);
        check("count_warmup_excl", result_count, {9'd256, 9'd0, 9'd0});
        check("class_warmup_excl", result_class, 2);

        input_value = {8'd0, 8'd128, 8'd0, 8'd128};
        for (int i = 0; i < IN_N; i++) o0[i] = ones[i];
        do_start();
        run(0, '0, '0, lat);
        check("latency_gen", lat, 272);
        step(1);
        check("gen_zero_ch1", ones[1] - o0[1], 0);
        check("gen_zero_ch3", ones[3] - o0[3], 0);
        check_range("gen_half_ch0", ones[0] - o0[0], 112, 144);
        check_range("gen_half_ch2", ones[2] - o0[2], 112, 144);

        for (int r = 0; r < 6; r++) begin
            input_value = $urandom;
            d0 = done_seen;
            do_start();
            run(0, '0, '0, lat);
            check("latency_random", lat, 272);
            step(1);
            check("done_pulses_random", done_seen - d0, 1);
        end

        held_rc  = result_count;
        held_cls = result_class;
        d0 = done_seen;
        input_value = $urandom;
        do_start();
        for (int k = 1; k <= 115; k++) begin
            bs_output = 3'($urandom);
            start     = (k == 50);
            step(1);
        end
        start = 1'b0;
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_count_held", result_count, held_rc);
        step(300);
        check("abort_no_done", done_seen - d0, 0);
        check("abort_class_held", result_class, held_cls);

        input_value = $urandom;
        cap = 1;
        do_start();
        step(149);
        #2 n_rst = 1'b0;
        #1;
        check("midreset_ready", ready, 1);
        check("midreset_done", done, 0);
        check("midreset_bs_input", bs_input, 0);
        check("midreset_count", result_count, 0);
        check("midreset_class", result_class, 0);
        check("midreset_valid", result_valid, 0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        cap = 2;
        do_start();
        run(0, '0, '0, lat);
        check("latency_after_reset", lat, 272);
        step(1);
        cap = 0;
        check("valid_after_reset", result_valid, 1);
        mism = 0;
        for (int e = 0; e < 140; e++) if (seq_a[e] !== seq_b[e]) mism++;
        check("rerun_sequence", mism, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bitstream_runner.md
BITSTREAM_RUNNER -- requirements
Module: bitstream_runner

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 4, number of stochastic input channels.
REQ-002 SHALL have parameter OUTPUT_SIZE, default 3, number of output channels (≥2).
REQ-003 SHALL have parameter VALUE_WIDTH, default 8, input value width (unsigned).
REQ-004 SHALL have parameter WARMUP, default 16, pipeline-flush cycles before counting (0 allowed).
REQ-005 SHALL have parameter WINDOW, default 256, counting cycles per evaluation (≥1).
REQ-006 SHALL have parameter SEED, default 25, base LFSR seed.
REQ-007 SHALL have port clk  in  1  clock; one clock, all logic on rising edge.
REQ-008 SHALL have port n_rst  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port start  in  1  request evaluation.
REQ-010 SHALL have port abort  in  1  cancel evaluation in progress.
REQ-011 SHALL have port input_value  in  INPUT_SIZE*VALUE_WIDTH  packed values, channel i at bits [i*VALUE_WIDTH +: VALUE_WIDTH].
REQ-012 SHALL have port bs_input  out  INPUT_SIZE  generated bitstreams to layer network.
REQ-013 SHALL have port bs_output  in  OUTPUT_SIZE  bitstreams returned from layer network.
REQ-014 SHALL have port ready  out  1  high in IDLE.
REQ-015 SHALL have port done  out  1  one-cycle completion pulse.
REQ-016 SHALL have port result_count  out  OUTPUT_SIZE*CW  per-channel ones count, CW=$clog2(WINDOW+1).
REQ-017 SHALL have port result_class  out  max(1,$clog2(OUTPUT_SIZE))  argmax channel index.
REQ-018 SHALL have port result_valid  out  1  high once any evaluation completed, until reset.

Function
REQ-019 SHALL implement FSM IDLE→WARMUP→COUNT→DONE→IDLE; WARMUP skipped when WARMUP=0.
REQ-020 SHALL, on start=1 in IDLE, latch input_value, clear counters, reseed LFSRs, enter WARMUP next cycle.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL stay in WARMUP exactly WARMUP cycles and in COUNT exactly WINDOW cycles, then DONE one cycle.
REQ-023 SHALL assert done exactly in the DONE cycle, i.e. cycle T+1+WARMUP+WINDOW for start sampled at edge T.
REQ-024 SHALL use per input a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed (SEED+i*235) mod 65536, zero seed replaced by 16'h0001.
REQ-025 SHALL advance LFSRs every WARMUP/COUNT cycle and hold them otherwise.
REQ-026 SHALL drive bs_input[i] = (lfsr_i[VALUE_WIDTH-1:0] < latched value_i) in WARMUP/COUNT, 0 in IDLE/DONE; value 0 gives constant 0.
REQ-027 SHALL increment counter j on each COUNT-cycle edge where bs_output[j]=1; bs_output ignored in all other states.
REQ-028 SHALL size counters CW bits; no overflow possible (max WINDOW).
REQ-029 SHALL, at the edge leaving DONE, load result_count from counters, result_class as argmax (tie → lowest index), set result_valid.
REQ-030 SHALL hold result outputs unchanged between completions.
REQ-031 SHALL, on abort=1 in WARMUP/COUNT/DONE, return to IDLE next cycle with no done pulse and results unchanged; abort has priority over completion; abort in IDLE has no effect.
REQ-032 SHALL, on simultaneous start and abort in IDLE, start (abort ignored in IDLE).

Reset
REQ-033 SHALL, on n_rst=0, immediately force IDLE, ready=1, done=0, bs_input=0, result_count=0, result_class=0, result_valid=0, counters 0, LFSRs to seeds.
REQ-034 SHALL discard any evaluation in progress on reset, with no done pulse.

Structure
REQ-035 SHALL place the FSM state enum and LFSR polynomial/seed-stride constants in package bitstream_pkg.
REQ-036 SHALL instantiate one sub-module lfsr16 (seed parameter, load, enable, 16-bit state output) per input channel.

Verification
REQ-037 SHALL check reset: after n_rst release, ready=1, all other outputs 0.
REQ-038 SHALL check defaults with bs_output=3'b101: start at T → done at T+273, result_count={256,0,256}, result_class=0, result_valid=1.
REQ-039 SHALL check warmup exclusion: bs_output=3'b010 during WARMUP, 3'b100 during COUNT → counts {0,0,256}, class 2.
REQ-040 SHALL check generators: value 0 → bs_input[i]=0 for all cycles; value 128 → ones in 256-cycle window within 128±16.
REQ-041 SHALL check abort at COUNT cycle 100 → ready next cycle, no done, prior results held; start while busy ignored (done count stays 1).
REQ-042 SHALL check n_rst pulse mid-COUNT → immediate IDLE with outputs 0; a subsequent start completes normally with identical bs_input sequence to first run.
